// File: rtl/ps2encoder.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues
// request-to-send, shifts out one byte plus odd parity on device clock edges.
`timescale 1ns/1ps
module ps2encoder #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       i_clock,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int MAX_CNT = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, BITS, ACK, RELEASE
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       bit_cnt, bit_cnt_d;
  logic [7:0]       tx_byte, tx_byte_d;
  logic             parity, parity_d;
  logic             drive_low, drive_low_d;
  logic             done_d, error_d;

  // Bit 2 is the previous synced clock sample, bit 1 the current one.
  logic [2:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_fall, clk_synced, data_synced, timeout;

  assign clk_synced  = clk_sync[1];
  assign data_synced = data_sync[1];
  assign clk_fall    = clk_sync[2] & ~clk_sync[1];
  assign timeout     = (cnt == TIMEOUT_LAST);

  // Idle-high bus: synchronizers reset to 1 so release never looks like an edge.
  always_ff @(posedge i_clock or negedge reset) begin
    if (!reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
    end
  end

  // NOTE: every state element uses <= so all flops update from the same pre-edge values.
  always_ff @(posedge i_clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      tx_byte   <= '0;
      parity    <= 1'b0;
      drive_low <= 1'b0;
      tx_done   <= 1'b0;
      tx_error  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bit_cnt   <= bit_cnt_d;
      tx_byte   <= tx_byte_d;
      parity    <= parity_d;
      drive_low <= drive_low_d;
      tx_done   <= done_d;
      tx_error  <= error_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    bit_cnt_d   = bit_cnt;
    tx_byte_d   = tx_byte;
    parity_d    = parity;
    drive_low_d = drive_low;
    done_d      = 1'b0;
    error_d     = 1'b0;

    case (state)
      IDLE: begin
        if (tx_start) begin
          tx_byte_d = tx_data;
          parity_d  = ~^tx_data;
          cnt_d     = '0;
          state_d   = INHIBIT;
        end
      end

      INHIBIT: begin
        cnt_d = cnt + 1'b1;
        if (cnt == INHIBIT_LAST) state_d = RTS;
      end

      RTS: begin
        cnt_d       = '0;
        bit_cnt_d   = '0;
        drive_low_d = 1'b1;
        state_d     = BITS;
      end

      BITS: begin
        cnt_d = cnt + 1'b1;
        if (timeout) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else if (clk_fall) begin
          bit_cnt_d = bit_cnt + 1'b1;
          if (bit_cnt < 4'd8) begin
            drive_low_d = ~tx_byte[bit_cnt[2:0]];
          end else if (bit_cnt == 4'd8) begin
            drive_low_d = ~parity;
          end else begin
            // Tenth edge: stop bit is a released line; the counter stops here.
            drive_low_d = 1'b0;
            bit_cnt_d   = bit_cnt;
            state_d     = ACK;
          end
        end
      end

      ACK: begin
        cnt_d = cnt + 1'b1;
        if (timeout) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else if (clk_fall) begin
          if (data_synced) begin
            state_d = IDLE;
            error_d = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end
      end

      RELEASE: begin
        cnt_d = cnt + 1'b1;
        if (timeout) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else if (clk_synced && data_synced) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Line drives decode straight from state so reset releases the bus at once.
  assign busy        = (state != IDLE);
  assign ps2_clk_oe  = (state == INHIBIT) || (state == RTS);
  assign ps2_data_oe = (state == RTS) || ((state == BITS) && drive_low);

endmodule

// File: tb/tb_ps2encoder.sv
// Directed bench for ps2encoder: a PS/2 device model clocks frames out of the
// host and checks bit order, parity, ACK handling, timeout and reset abort.
`timescale 1ns/1ps
module tb_ps2encoder;

  localparam int HALF = 40;

  logic       i_clock = 1'b0;
  logic       reset   = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  // Open-drain bus with pull-ups: either side can only pull low.
  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2encoder #(.INHIBIT_CYCLES(8), .TIMEOUT_CYCLES(2000)) dut (
    .i_clock     (i_clock),
    .reset       (reset),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error)
  );

  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc++;

  int done_cnt = 0, err_cnt = 0, bad_cnt = 0, last_err_cyc = 0;
  always @(negedge i_clock) begin
    if (tx_done) done_cnt++;
    if (tx_error) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if ((tx_done && tx_error) || ((tx_done || tx_error) && busy)) bad_cnt++;
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_xfer(input logic [7:0] d, output int inh, output int rel);
    @(negedge i_clock);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge i_clock);
    tx_start = 1'b0;
    check("busy_after_start", busy, 1);
    inh = 0;
    while (ps2_clk_oe && !ps2_data_oe && inh < 100) begin
      inh++;
      @(negedge i_clock);
    end
    check("rts_lines", {ps2_clk_oe, ps2_data_oe}, 2'b11);
    @(negedge i_clock);
    check("rts_release", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    rel = cyc;
  endtask

  task automatic clock_edges(input int n_edges, input bit ack, output logic [9:0] bits);
    bits = '0;
    for (int n = 1; n <= n_edges; n++) begin
      if (n == 11 && ack) dev_data = 1'b0;
      repeat (HALF) @(negedge i_clock);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge i_clock);
      dev_clk = 1'b1;
      if (n <= 10) bits[n-1] = ps2_data_in;
      if (n == 11) dev_data = 1'b1;
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 60 && busy; k++) @(negedge i_clock);
    repeat (10) @(negedge i_clock);
    check(tag, busy, 0);
  endtask

  int         inh, rel, d0, e0;
  logic [9:0] bits;

  initial begin
    // Reset state
    repeat (3) @(negedge i_clock);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {tx_done, tx_error}, 2'b00);
    reset = 1'b1;
    repeat (3) @(negedge i_clock);

    // 0xED with ACK
    d0 = done_cnt; e0 = err_cnt;
    start_xfer(8'hED, inh, rel);
    check("ed_inhibit_len", inh, 8);
    clock_edges(11, 1'b1, bits);
    check("ed_frame", bits, 10'h3ED);
    wait_idle("ed_idle");
    check("ed_done", done_cnt - d0, 1);
    check("ed_err", err_cnt - e0, 0);
    check("ed_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    // 0xF4 with ACK and an ignored second request
    d0 = done_cnt; e0 = err_cnt;
    start_xfer(8'hF4, inh, rel);
    @(negedge i_clock);
    tx_data  = 8'h11;
    tx_start = 1'b1;
    @(negedge i_clock);
    tx_start = 1'b0;
    check("f4_busy_hold", busy, 1);
    clock_edges(11, 1'b1, bits);
    check("f4_frame", bits, 10'h2F4);
    wait_idle("f4_idle");
    check("f4_done", done_cnt - d0, 1);
    check("f4_err", err_cnt - e0, 0);
    check("f4_no_restart", {ps2_clk_oe, busy}, 2'b00);

    // No ACK on edge 11
    d0 = done_cnt; e0 = err_cnt;
    start_xfer(8'h55, inh, rel);
    clock_edges(11, 1'b0, bits);
    check("nak_frame", bits, 10'h355);
    wait_idle("nak_idle");
    check("nak_err", err_cnt - e0, 1);
    check("nak_done", done_cnt - d0, 0);
    check("nak_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    // Device stops clocking after edge 4
    d0 = done_cnt; e0 = err_cnt;
    start_xfer(8'hA3, inh, rel);
    clock_edges(4, 1'b0, bits);
    for (int k = 0; k < 3000 && err_cnt == e0; k++) @(negedge i_clock);
    check("to_err", err_cnt - e0, 1);
    check("to_latency", last_err_cyc - rel, 2000);
    check("to_done", done_cnt - d0, 0);
    check("to_lines", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);

    // Reset during edge 5 of 0x0F (bit 4 = 0, so data is driven low)
    d0 = done_cnt; e0 = err_cnt;
    start_xfer(8'h0F, inh, rel);
    clock_edges(4, 1'b0, bits);
    repeat (HALF) @(negedge i_clock);
    dev_clk = 1'b0;
    repeat (5) @(negedge i_clock);
    check("e5_driving", ps2_data_oe, 1);
    reset = 1'b0;
    #1;
    check("e5_rst_lines", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
    repeat (3) @(negedge i_clock);
    dev_clk = 1'b1;
    reset   = 1'b1;
    repeat (60) @(negedge i_clock);
    check("e5_no_pulses", {done_cnt - d0, err_cnt - e0}, 64'd0);
    check("e5_stays_idle", {ps2_clk_oe, busy}, 2'b00);

    // 0x00 after reset: parity 1
    d0 = done_cnt; e0 = err_cnt;
    start_xfer(8'h00, inh, rel);
    check("z_inhibit_len", inh, 8);
    clock_edges(11, 1'b1, bits);
    check("z_frame", bits, 10'h300);
    wait_idle("z_idle");
    check("z_done", done_cnt - d0, 1);
    check("z_err", err_cnt - e0, 0);

    check("pulse_rules", bad_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
